shift_pattern_decoder: RTL



---
 rtl/shift_pat_pkg.sv | 38 +++
 rtl/shift_step_classifier.sv | 36 +++
 rtl/shift_pattern_decoder.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/shift_pat_pkg.sv
// Shared types for the LED shift-pattern decoder: animation modes, step classes
// and the classifier result bundle.
package shift_pat_pkg;

  typedef enum logic [2:0] {
    NONE  = 3'd0,
    OFF   = 3'd1,
    ROT_L = 3'd2,
    ROT_R = 3'd3,
    KITT  = 3'd4
  } mode_t;

  typedef enum logic [3:0] {
    ZERO,
    TO_ZERO,
    FROM_ZERO,
    HOLD,
    WRAP_L,
    WRAP_R,
    LEFT,
    RIGHT,
    BAD
  } step_t;

  localparam logic [7:0] PAT_MSB = 8'h80;
  localparam logic [7:0] PAT_LSB = 8'h01;

  typedef struct packed {
    step_t      step;
    logic       onehot;
    logic [2:0] pos;
  } step_res_t;

  function automatic logic is_onehot(input logic [7:0] v);
    return (v != 8'h00) && ((v & (v - 8'h01)) == 8'h00);
  endfunction

endpackage

// File: rtl/shift_step_classifier.sv
// Combinational step classifier: relates the stored sample to the new one and
// reports the new sample's one-hot flag and lit-bit index.
module shift_step_classifier
  import shift_pat_pkg::*;
(
  input  logic [7:0] prev,
  input  logic [7:0] cur,
  output step_res_t  res
);

  logic p_oh, c_oh;

  assign p_oh = is_onehot(prev);
  assign c_oh = is_onehot(cur);

  always_comb begin
    res.step   = BAD;
    res.onehot = c_oh;
    res.pos    = '0;
    for (int i = 0; i < 8; i++)
      if (c_oh && cur[i]) res.pos = 3'(i);

    // Any non-one-hot nonzero value on either side falls through to BAD.
    if (prev == 8'h00 && cur == 8'h00)      res.step = ZERO;
    else if (p_oh && cur == 8'h00)          res.step = TO_ZERO;
    else if (prev == 8'h00 && c_oh)         res.step = FROM_ZERO;
    else if (p_oh && c_oh) begin
      if (cur == prev)                                res.step = HOLD;
      else if (prev == PAT_MSB && cur == PAT_LSB)     res.step = WRAP_L;
      else if (prev == PAT_LSB && cur == PAT_MSB)     res.step = WRAP_R;
      else if (cur == {prev[6:0], 1'b0})              res.step = LEFT;
      else if (cur == {1'b0, prev[7:1]})              res.step = RIGHT;
    end
  end

endmodule

// File: rtl/shift_pattern_decoder.sv
// LED animation decoder: classifies the sampled pattern stream as off, rotate
// left/right or KITT ping-pong and builds confidence toward a lock.
module shift_pattern_decoder
  import shift_pat_pkg::*;
#(
  parameter int LOCK_STEPS = 4,
  parameter int CNT_W      = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       step_en,
  input  logic [7:0] pattern,
  output logic [2:0] mode,
  output logic       locked,
  output logic [2:0] position,
  output logic       pos_valid,
  output logic       dir,
  output logic       err
);

  localparam logic [CNT_W-1:0] LOCK_C = CNT_W'(LOCK_STEPS);
  localparam logic [CNT_W-1:0] CNT_1  = CNT_W'(1);

  logic [7:0]       prev_q, prev_d;
  logic             prev_valid_q, prev_valid_d;
  mode_t            mode_q, mode_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic             locked_q, locked_d;
  logic [2:0]       pos_q, pos_d;
  logic             pos_valid_q, pos_valid_d;
  logic             dir_q, dir_d;
  logic             err_q, err_d;

  step_res_t        res;
  logic             is_left, mv_dir, wrap, reverse, consistent;
  mode_t            tgt;

  shift_step_classifier u_cls (
    .prev (prev_q),
    .cur  (pattern),
    .res  (res)
  );

  assign cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + CNT_1;

  assign is_left = (res.step == LEFT) || (res.step == WRAP_L);
  assign mv_dir  = (res.step == RIGHT) || (res.step == WRAP_R);
  assign wrap    = (res.step == WRAP_L) || (res.step == WRAP_R);
  assign tgt     = is_left ? ROT_L : ROT_R;
  // A bounce off an edge against the last direction is what marks KITT.
  assign reverse = ((res.step == RIGHT) && (prev_q == PAT_MSB) && !dir_q) ||
                   ((res.step == LEFT)  && (prev_q == PAT_LSB) &&  dir_q);
  assign consistent = (mode_q == tgt) ||
                      ((mode_q == KITT) && !wrap && (dir_q == mv_dir));

  always_comb begin
    prev_d       = prev_q;
    prev_valid_d = prev_valid_q;
    mode_d       = mode_q;
    cnt_d        = cnt_q;
    pos_d        = pos_q;
    pos_valid_d  = pos_valid_q;
    dir_d        = dir_q;
    err_d        = 1'b0;

    if (step_en) begin
      prev_d       = pattern;
      prev_valid_d = 1'b1;
      pos_d        = res.pos;
      pos_valid_d  = res.onehot;

      if (prev_valid_q) begin
        case (res.step)
          ZERO: begin
            if (mode_q == OFF) cnt_d = cnt_inc;
            else begin
              mode_d = OFF;
              cnt_d  = CNT_1;
            end
          end
          TO_ZERO: begin
            mode_d = OFF;
            cnt_d  = CNT_1;
          end
          FROM_ZERO: begin
            mode_d = NONE;
            cnt_d  = '0;
          end
          HOLD: ;
          LEFT, RIGHT, WRAP_L, WRAP_R: begin
            dir_d = mv_dir;
            if (reverse) begin
              cnt_d  = (mode_q == KITT) ? cnt_inc : CNT_1;
              mode_d = KITT;
            end else if (consistent) begin
              cnt_d = cnt_inc;
            end else begin
              mode_d = tgt;
              cnt_d  = CNT_1;
              err_d  = (mode_q != NONE);
            end
          end
          default: begin
            mode_d = NONE;
            cnt_d  = '0;
            err_d  = 1'b1;
          end
        endcase
      end
    end

    locked_d = (cnt_d >= LOCK_C);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      prev_q       <= '0;
      prev_valid_q <= 1'b0;
      mode_q       <= NONE;
      cnt_q        <= '0;
      locked_q     <= 1'b0;
      pos_q        <= '0;
      pos_valid_q  <= 1'b0;
      dir_q        <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      prev_q       <= prev_d;
      prev_valid_q <= prev_valid_d;
      mode_q       <= mode_d;
      cnt_q        <= cnt_d;
      locked_q     <= locked_d;
      pos_q        <= pos_d;
      pos_valid_q  <= pos_valid_d;
      dir_q        <= dir_d;
      err_q        <= err_d;
    end
  end

  assign mode      = mode_q;
  assign locked    = locked_q;
  assign position  = pos_q;
  assign pos_valid = pos_valid_q;
  assign dir       = dir_q;
  assign err       = err_q;

endmodule
